// File: rtl/hcode_shell_pkg.sv
// Shared definitions for the hcode shell: default widths, arbiter FSM state
// type and a constant-foldable clog2 helper.
package hcode_shell_pkg;

   localparam int N_CH_DEF   = 4;
   localparam int DATA_W_DEF = 128;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/hcode_buf2.sv
// Two-entry FIFO buffer with registered full flag; writes while full are
// dropped, simultaneous push and pop keep the occupancy unchanged.
module hcode_buf2
   import hcode_shell_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem_r [2];
   logic              wr_ptr_r;
   logic              rd_ptr_r;
   logic [1:0]        count_r;
   logic              full_r;
   logic              push_ok_s;
   logic              pop_ok_s;
   logic [1:0]        count_nxt_s;

   assign push_ok_s = push && !full_r;
   assign pop_ok_s  = pop && (count_r != 2'd0);
   assign dout      = mem_r[rd_ptr_r];
   assign full      = full_r;
   assign empty     = (count_r == 2'd0);

   // Next occupancy from accepted push/pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + 2'd1;
         2'b01:   count_nxt_s = count_r - 2'd1;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage, pointers and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r[0] <= {DATA_W{1'b0}};
         mem_r[1] <= {DATA_W{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
         full_r   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == 2'd2);
      end
   end

endmodule

// File: rtl/hcode_out_rr_arbiter.sv
// Merges N_CH subshell output streams onto the host write FIFO with
// round-robin burst arbitration; each word carries its source channel tag.
module hcode_out_rr_arbiter
   import hcode_shell_pkg::*;
#(
   parameter int N_CH      = N_CH_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 16,
   parameter int CH_W      = clog2(N_CH)
) (
   input  logic                   ip_clk,
   input  logic                   ip_rst_n,
   input  logic [N_CH-1:0]        cfg_ch_en,
   input  logic [N_CH*DATA_W-1:0] sub_out_din,
   input  logic [N_CH-1:0]        sub_out_write,
   output logic [N_CH-1:0]        sub_out_full,
   output logic [DATA_W-1:0]      host_din,
   output logic                   host_write,
   input  logic                   host_full,
   output logic [CH_W-1:0]        host_chan
);

   localparam int              BC_W   = clog2(MAX_BURST + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BURST);

   logic [N_CH-1:0]   buf_empty_s;
   logic [N_CH-1:0]   eligible_s;
   logic [N_CH-1:0]   pop_s;
   logic [DATA_W-1:0] buf_dout_s [N_CH];

   arb_state_e        state_r, state_nxt_s;
   logic [CH_W-1:0]   grant_r, grant_nxt_s;
   logic [CH_W-1:0]   rr_ptr_r, rr_nxt_s;
   logic [BC_W-1:0]   burst_cnt_r, cnt_nxt_s, bc_inc_s;
   logic              search_hit_s;
   logic [CH_W-1:0]   search_sel_s;
   logic [CH_W:0]     search_sum_s;
   logic [CH_W-1:0]   search_idx_s;
   logic              can_load_s;
   logic              load_s;
   logic [CH_W-1:0]   pop_ch_s;

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      logic [CH_W-1:0] nxt;
      if (ch == CH_W'(N_CH - 1)) begin
         nxt = CH_W'(0);
      end else begin
         nxt = ch + CH_W'(1);
      end
      return nxt;
   endfunction

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      hcode_buf2 #(.DATA_W(DATA_W)) u_buf (
         .clk   (ip_clk),
         .rst_n (ip_rst_n),
         .push  (sub_out_write[i]),
         .din   (sub_out_din[i*DATA_W +: DATA_W]),
         .pop   (pop_s[i]),
         .dout  (buf_dout_s[i]),
         .full  (sub_out_full[i]),
         .empty (buf_empty_s[i])
      );
      assign pop_s[i] = load_s && (pop_ch_s == CH_W'(i));
   end

   assign eligible_s = ~buf_empty_s & cfg_ch_en;
   assign can_load_s = !host_write || !host_full;
   assign bc_inc_s   = burst_cnt_r + BC_W'(1);

   // First eligible channel searching upward from the rr pointer.
   always_comb begin
      search_hit_s = 1'b0;
      search_sel_s = rr_ptr_r;
      search_sum_s = {(CH_W+1){1'b0}};
      search_idx_s = rr_ptr_r;
      for (int k = 0; k < N_CH; k++) begin
         search_sum_s = {1'b0, rr_ptr_r} + (CH_W+1)'(k);
         if (search_sum_s >= (CH_W+1)'(N_CH)) begin
            search_sum_s = search_sum_s - (CH_W+1)'(N_CH);
         end else begin
            search_sum_s = search_sum_s;
         end
         search_idx_s = search_sum_s[CH_W-1:0];
         if (!search_hit_s && eligible_s[search_idx_s]) begin
            search_hit_s = 1'b1;
            search_sel_s = search_idx_s;
         end else begin
            search_hit_s = search_hit_s;
         end
      end
   end

   // Grant FSM: IDLE grants and loads in the same cycle so rotation costs no bubble.
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      rr_nxt_s    = rr_ptr_r;
      cnt_nxt_s   = burst_cnt_r;
      load_s      = 1'b0;
      pop_ch_s    = grant_r;
      case (state_r)
         IDLE: begin
            if (search_hit_s) begin
               grant_nxt_s = search_sel_s;
               pop_ch_s    = search_sel_s;
               if (can_load_s) begin
                  load_s = 1'b1;
                  if (BC_MAX == BC_W'(1)) begin
                     state_nxt_s = IDLE;
                     rr_nxt_s    = next_ch(search_sel_s);
                     cnt_nxt_s   = BC_W'(0);
                  end else begin
                     state_nxt_s = BURST;
                     cnt_nxt_s   = BC_W'(1);
                  end
               end else begin
                  state_nxt_s = BURST;
                  cnt_nxt_s   = BC_W'(0);
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BURST: begin
            if (!cfg_ch_en[grant_r]) begin
               state_nxt_s = IDLE;
               rr_nxt_s    = next_ch(grant_r);
               cnt_nxt_s   = BC_W'(0);
            end else if (can_load_s) begin
               if (!buf_empty_s[grant_r]) begin
                  load_s = 1'b1;
                  if (bc_inc_s == BC_MAX) begin
                     state_nxt_s = IDLE;
                     rr_nxt_s    = next_ch(grant_r);
                     cnt_nxt_s   = BC_W'(0);
                  end else begin
                     cnt_nxt_s = bc_inc_s;
                  end
               end else begin
                  state_nxt_s = IDLE;
                  rr_nxt_s    = next_ch(grant_r);
                  cnt_nxt_s   = BC_W'(0);
               end
            end else begin
               cnt_nxt_s = burst_cnt_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = BC_W'(0);
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         state_r     <= IDLE;
         grant_r     <= CH_W'(0);
         rr_ptr_r    <= CH_W'(0);
         burst_cnt_r <= BC_W'(0);
      end else begin
         state_r     <= state_nxt_s;
         grant_r     <= grant_nxt_s;
         rr_ptr_r    <= rr_nxt_s;
         burst_cnt_r <= cnt_nxt_s;
      end
   end

   // Output register: holds while the host FIFO is full.
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         host_write <= 1'b0;
         host_din   <= {DATA_W{1'b0}};
         host_chan  <= CH_W'(0);
      end else if (load_s) begin
         host_write <= 1'b1;
         host_din   <= buf_dout_s[pop_ch_s];
         host_chan  <= pop_ch_s;
      end else if (!host_full) begin
         host_write <= 1'b0;
      end
   end

endmodule
